// File: rtl/ps2_mouse_decoder.sv
// ps2_mouse_decoder
//   Receives the device-driven PS/2 mouse stream and assembles standard
//   3-byte movement packets. The 9-bit two's-complement X/Y deltas are
//   converted to an 8-bit saturated magnitude plus a sign flag. Deltas and
//   sign flags are non-zero only during the single o_valid cycle.
// Ports:
//   clk, arst_n        system clock, asynchronous active-low reset
//   i_ps2_clk          PS/2 clock from device (asynchronous)
//   i_ps2_data         PS/2 data from device (asynchronous)
//   o_mouse_dx/dy      |delta|, saturated to 255, 0 outside o_valid
//   o_is_mouse_dx_neg  X delta sign, 0 outside o_valid
//   o_is_mouse_dy_neg  Y delta sign, 0 outside o_valid
//   o_btn_left/right   button state, held from the last good packet
//   o_valid            one-cycle pulse per decoded packet
//   o_frame_err        one-cycle pulse on framing/parity/sync error
module ps2_mouse_decoder #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_mouse_dx,
  output logic [7:0] o_mouse_dy,
  output logic       o_is_mouse_dx_neg,
  output logic       o_is_mouse_dy_neg,
  output logic       o_btn_left,
  output logic       o_btn_right,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Input synchronizers; idle PS/2 lines are high, so reset to 1
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic ps2_clk_s, ps2_data_s;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], i_ps2_data};
    end
  end

  assign ps2_clk_s  = clk_sync[SYNC_STAGES-1];
  assign ps2_data_s = data_sync[SYNC_STAGES-1];

  // Glitch filter: level flips only after FILTER_LEN consecutive samples
  // that differ from the current filtered level
  logic [FW-1:0] flt_cnt;
  logic          flt_clk, flt_clk_d, sample;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      flt_cnt   <= '0;
      flt_clk   <= 1'b1;
      flt_clk_d <= 1'b1;
    end else begin
      flt_clk_d <= flt_clk;
      if (ps2_clk_s == flt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        flt_clk <= ps2_clk_s;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign sample = flt_clk_d & ~flt_clk;

  // Timeout supervision
  state_t        state, state_nxt;
  logic [1:0]    pkt_idx;
  logic [TW-1:0] to_cnt;
  logic          timeout;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                              to_cnt <= '0;
    else if (sample)                          to_cnt <= '0;
    else if (to_cnt != TW'(TIMEOUT_CYCLES))   to_cnt <= to_cnt + 1'b1;
  end

  // A sample event counts as activity, so it is never discarded by timeout
  assign timeout = !sample && (to_cnt == TW'(TIMEOUT_CYCLES)) &&
                   ((state != S_IDLE) || (pkt_idx != 2'd0));

  // Bit FSM
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       par_bit;
  logic       idle_err, byte_done, byte_err, byte_ok;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = S_IDLE;
    end else if (sample) begin
      unique case (state)
        S_IDLE:   if (!ps2_data_s) state_nxt = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
        S_PARITY: state_nxt = S_STOP;
        S_STOP:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    byte_ok   = ps2_data_s && (^{shreg, par_bit});
    idle_err  = sample && (state == S_IDLE) && ps2_data_s;
    byte_done = sample && (state == S_STOP) && byte_ok;
    byte_err  = sample && (state == S_STOP) && !byte_ok;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else if (sample) begin
      unique case (state)
        S_IDLE:   bit_cnt <= '0;
        S_DATA: begin
          shreg   <= {ps2_data_s, shreg[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        S_PARITY: par_bit <= ps2_data_s;
        default:  ;
      endcase
    end
  end

  // Packet assembly; header keeps {y_ovf, x_ovf, y_sign, x_sign, right, left}
  logic [5:0] hdr;
  logic [7:0] b1;
  logic       sync_err, pkt_done;

  assign sync_err = byte_done && (pkt_idx == 2'd0) && !shreg[3];
  assign pkt_done = byte_done && (pkt_idx == 2'd2);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pkt_idx <= 2'd0;
      hdr     <= '0;
      b1      <= '0;
    end else if (timeout || byte_err) begin
      pkt_idx <= 2'd0;
    end else if (byte_done) begin
      unique case (pkt_idx)
        2'd0: if (shreg[3]) begin
          hdr     <= {shreg[7:4], shreg[1:0]};
          pkt_idx <= 2'd1;
        end
        2'd1: begin
          b1      <= shreg;
          pkt_idx <= 2'd2;
        end
        default: pkt_idx <= 2'd0;
      endcase
    end
  end

  // Delta decode; byte 2 is still in the shift register when it completes
  logic [8:0] x, y, x_mag, y_mag;
  logic [7:0] dx_sat, dy_sat;

  always_comb begin
    x      = {hdr[2], b1};
    y      = {hdr[3], shreg};
    x_mag  = x[8] ? (9'd0 - x) : x;
    y_mag  = y[8] ? (9'd0 - y) : y;
    dx_sat = (hdr[4] || x_mag[8]) ? 8'hFF : x_mag[7:0];
    dy_sat = (hdr[5] || y_mag[8]) ? 8'hFF : y_mag[7:0];
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      o_valid           <= 1'b0;
      o_frame_err       <= 1'b0;
      o_mouse_dx        <= '0;
      o_mouse_dy        <= '0;
      o_is_mouse_dx_neg <= 1'b0;
      o_is_mouse_dy_neg <= 1'b0;
      o_btn_left        <= 1'b0;
      o_btn_right       <= 1'b0;
    end else begin
      o_valid           <= pkt_done;
      o_frame_err       <= idle_err || byte_err || sync_err;
      o_mouse_dx        <= pkt_done ? dx_sat : '0;
      o_mouse_dy        <= pkt_done ? dy_sat : '0;
      o_is_mouse_dx_neg <= pkt_done && x[8];
      o_is_mouse_dy_neg <= pkt_done && y[8];
      if (pkt_done) begin
        o_btn_left  <= hdr[0];
        o_btn_right <= hdr[1];
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
module tb_ps2_mouse_decoder;

  localparam int unsigned TO_CYCLES = 1000;
  localparam int unsigned HALF      = 400;   // ns, PS/2 half period
  localparam int unsigned GAP       = 1000;  // ns between bytes

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] dx, dy;
  logic       dxn, dyn, btnl, btnr, valid, ferr;

  ps2_mouse_decoder #(
    .SYNC_STAGES   (2),
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(TO_CYCLES)
  ) dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .i_ps2_clk        (ps2_clk),
    .i_ps2_data       (ps2_data),
    .o_mouse_dx       (dx),
    .o_mouse_dy       (dy),
    .o_is_mouse_dx_neg(dxn),
    .o_is_mouse_dy_neg(dyn),
    .o_btn_left       (btnl),
    .o_btn_right      (btnr),
    .o_valid          (valid),
    .o_frame_err      (ferr)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Output monitor, sampled on the falling system clock edge
  int         valid_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [7:0] cap_dx, cap_dy, post_dx, post_dy;
  logic       cap_dxn, cap_dyn, cap_btnl, cap_btnr, post_valid, prev_valid = 1'b0;

  always @(negedge clk) begin
    if (prev_valid) begin
      post_dx    = dx;
      post_dy    = dy;
      post_valid = valid;
    end
    if (valid) begin
      valid_cnt++;
      cap_dx   = dx;   cap_dy   = dy;
      cap_dxn  = dxn;  cap_dyn  = dyn;
      cap_btnl = btnl; cap_btnr = btnr;
    end
    if (ferr) err_cnt++;
    if (valid && ferr) both_cnt++;
    prev_valid = valid;
  end

  task automatic clr();
    valid_cnt  = 0;
    err_cnt    = 0;
    cap_dx     = 8'hAA; cap_dy = 8'hAA;
    cap_dxn    = 1'bx;  cap_dyn = 1'bx;
    post_dx    = 8'hAA; post_dy = 8'hAA;
    post_valid = 1'bx;
  endtask

  // Sends the first nbits of an 11-bit frame (start, 8 data LSB first, parity, stop)
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int unsigned nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int unsigned i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      #(HALF);
      ps2_clk = 1'b0;
      #(HALF);
      ps2_clk = 1'b1;
    end
    #(HALF);
    ps2_data = 1'b1;
    #(GAP);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_frame(b0, 1'b0, 11);
    send_frame(b1, 1'b0, 11);
    send_frame(b2, 1'b0, 11);
    #(2000);
  endtask

  task automatic test_reset();
    #(100);
    @(negedge clk);
    n_assert++;
    if ({dx, dy, dxn, dyn, btnl, btnr, valid, ferr} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, want 0", {dx, dy, dxn, dyn, btnl, btnr, valid, ferr});
    end
    arst_n = 1'b1;
    #(200);
  endtask

  task automatic test_basic();
    clr();
    send_packet(8'h08, 8'h05, 8'h03);
    n_assert++; if (valid_cnt !== 1)   begin n_fail++; $display("FAIL basic_valid_cnt: got %0d, want 1", valid_cnt); end
    n_assert++; if (err_cnt !== 0)     begin n_fail++; $display("FAIL basic_err_cnt: got %0d, want 0", err_cnt); end
    n_assert++; if (cap_dx !== 8'd5)   begin n_fail++; $display("FAIL basic_dx: got %0d, want 5", cap_dx); end
    n_assert++; if (cap_dy !== 8'd3)   begin n_fail++; $display("FAIL basic_dy: got %0d, want 3", cap_dy); end
    n_assert++; if (cap_dxn !== 1'b0)  begin n_fail++; $display("FAIL basic_dxn: got %b, want 0", cap_dxn); end
    n_assert++; if (cap_dyn !== 1'b0)  begin n_fail++; $display("FAIL basic_dyn: got %b, want 0", cap_dyn); end
    n_assert++; if ({cap_btnl, cap_btnr} !== 2'b00) begin n_fail++; $display("FAIL basic_btn: got %b, want 00", {cap_btnl, cap_btnr}); end
    n_assert++; if (post_valid !== 1'b0) begin n_fail++; $display("FAIL basic_post_valid: got %b, want 0", post_valid); end
    n_assert++; if ({post_dx, post_dy} !== 16'd0) begin n_fail++; $display("FAIL basic_post_delta: got %h, want 0", {post_dx, post_dy}); end
  endtask

  task automatic test_negative();
    clr();
    send_packet(8'h39, 8'hFB, 8'hFF);
    n_assert++; if (valid_cnt !== 1)  begin n_fail++; $display("FAIL neg_valid_cnt: got %0d, want 1", valid_cnt); end
    n_assert++; if (cap_dx !== 8'd5)  begin n_fail++; $display("FAIL neg_dx: got %0d, want 5", cap_dx); end
    n_assert++; if (cap_dxn !== 1'b1) begin n_fail++; $display("FAIL neg_dxn: got %b, want 1", cap_dxn); end
    n_assert++; if (cap_dy !== 8'd1)  begin n_fail++; $display("FAIL neg_dy: got %0d, want 1", cap_dy); end
    n_assert++; if (cap_dyn !== 1'b1) begin n_fail++; $display("FAIL neg_dyn: got %b, want 1", cap_dyn); end
    @(negedge clk);
    n_assert++; if ({btnl, btnr} !== 2'b10) begin n_fail++; $display("FAIL neg_btn_hold: got %b, want 10", {btnl, btnr}); end
    n_assert++; if ({dx, dxn} !== 9'd0) begin n_fail++; $display("FAIL neg_idle_dx: got %h, want 0", {dx, dxn}); end
  endtask

  task automatic test_saturation();
    clr();
    send_packet(8'h18, 8'h00, 8'h00);
    n_assert++; if (cap_dx !== 8'd255) begin n_fail++; $display("FAIL sat_m256_dx: got %0d, want 255", cap_dx); end
    n_assert++; if (cap_dxn !== 1'b1)  begin n_fail++; $display("FAIL sat_m256_dxn: got %b, want 1", cap_dxn); end
    n_assert++; if (cap_dy !== 8'd0)   begin n_fail++; $display("FAIL sat_m256_dy: got %0d, want 0", cap_dy); end
    clr();
    send_packet(8'h48, 8'h10, 8'h00);
    n_assert++; if (valid_cnt !== 1)   begin n_fail++; $display("FAIL sat_ovf_valid_cnt: got %0d, want 1", valid_cnt); end
    n_assert++; if (cap_dx !== 8'd255) begin n_fail++; $display("FAIL sat_ovf_dx: got %0d, want 255", cap_dx); end
    n_assert++; if (cap_dxn !== 1'b0)  begin n_fail++; $display("FAIL sat_ovf_dxn: got %b, want 0", cap_dxn); end
  endtask

  task automatic test_parity_error();
    clr();
    send_frame(8'h08, 1'b0, 11);
    send_frame(8'h02, 1'b1, 11);
    #(2000);
    n_assert++; if (err_cnt !== 1)   begin n_fail++; $display("FAIL par_err_cnt: got %0d, want 1", err_cnt); end
    n_assert++; if (valid_cnt !== 0) begin n_fail++; $display("FAIL par_no_valid: got %0d, want 0", valid_cnt); end
    clr();
    send_packet(8'h08, 8'h02, 8'h01);
    n_assert++; if (valid_cnt !== 1) begin n_fail++; $display("FAIL par_recover_valid: got %0d, want 1", valid_cnt); end
    n_assert++; if ({cap_dx, cap_dy} !== {8'd2, 8'd1}) begin n_fail++; $display("FAIL par_recover_delta: got %h, want 0201", {cap_dx, cap_dy}); end
  endtask

  task automatic test_sync_error();
    clr();
    send_frame(8'h00, 1'b0, 11);
    send_packet(8'h08, 8'h01, 8'h01);
    n_assert++; if (err_cnt !== 1)   begin n_fail++; $display("FAIL sync_err_cnt: got %0d, want 1", err_cnt); end
    n_assert++; if (valid_cnt !== 1) begin n_fail++; $display("FAIL sync_valid_cnt: got %0d, want 1", valid_cnt); end
    n_assert++; if ({cap_dx, cap_dy} !== {8'd1, 8'd1}) begin n_fail++; $display("FAIL sync_delta: got %h, want 0101", {cap_dx, cap_dy}); end
  endtask

  task automatic test_timeout();
    clr();
    send_frame(8'h55, 1'b0, 5);
    #((TO_CYCLES + 200) * 10);
    send_packet(8'h08, 8'h04, 8'h04);
    n_assert++; if (err_cnt !== 0)   begin n_fail++; $display("FAIL to_err_cnt: got %0d, want 0", err_cnt); end
    n_assert++; if (valid_cnt !== 1) begin n_fail++; $display("FAIL to_valid_cnt: got %0d, want 1", valid_cnt); end
    n_assert++; if ({cap_dx, cap_dy} !== {8'd4, 8'd4}) begin n_fail++; $display("FAIL to_delta: got %h, want 0404", {cap_dx, cap_dy}); end
  endtask

  task automatic test_reset_midframe();
    clr();
    send_packet(8'h0B, 8'h00, 8'h00);
    n_assert++; if ({btnl, btnr} !== 2'b11) begin n_fail++; $display("FAIL rst_btn_set: got %b, want 11", {btnl, btnr}); end
    send_frame(8'h0B, 1'b0, 11);
    send_frame(8'h33, 1'b0, 6);
    arst_n = 1'b0;
    #(100);
    @(negedge clk);
    n_assert++;
    if ({dx, dy, dxn, dyn, btnl, btnr, valid, ferr} !== 22'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %h, want 0", {dx, dy, dxn, dyn, btnl, btnr, valid, ferr});
    end
    arst_n = 1'b1;
    #(200);
    clr();
    send_packet(8'h08, 8'h07, 8'h09);
    n_assert++; if (err_cnt !== 0)   begin n_fail++; $display("FAIL rst_err_cnt: got %0d, want 0", err_cnt); end
    n_assert++; if (valid_cnt !== 1) begin n_fail++; $display("FAIL rst_valid_cnt: got %0d, want 1", valid_cnt); end
    n_assert++; if ({cap_dx, cap_dy} !== {8'd7, 8'd9}) begin n_fail++; $display("FAIL rst_delta: got %h, want 0709", {cap_dx, cap_dy}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_parity_error();
    test_sync_error();
    test_timeout();
    test_reset_midframe();
    n_assert++; if (both_cnt !== 0) begin n_fail++; $display("FAIL valid_with_err: got %0d, want 0", both_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
